// File: rtl/systolic_cluster_sequencer.sv
// Job sequencer for the systolic array cluster. Accepts one tile job at a
// time, optionally pulses an accumulator clear, waits for the target
// array(s), then streams K skewed A/B beats and drains the pipeline before
// reporting completion.
module systolic_cluster_sequencer #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 8,
  parameter int NUM_ARRAYS = 8,
  parameter int K_BITS     = 9,
  parameter int SEL_BITS   = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [SEL_BITS-1:0]             cmd_array,
  input  logic                            cmd_broadcast,
  input  logic                            cmd_clear,
  input  logic [K_BITS-1:0]               cmd_k,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] a_data,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] b_data,
  input  logic [NUM_ARRAYS-1:0]           arr_ready,
  output logic [SEL_BITS-1:0]             arr_select,
  output logic                            arr_broadcast,
  output logic                            arr_clear_acc,
  output logic                            arr_compute_enable,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] arr_a_flat,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] arr_b_flat,
  output logic                            done_valid,
  output logic [SEL_BITS-1:0]             done_array,
  output logic                            done_err,
  output logic                            busy
);

  localparam int DRAIN_CYC = 2 * ARRAY_SIZE - 2;
  localparam int DCNT_BITS = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int RDY_W     = 2 ** SEL_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_RDY, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [SEL_BITS-1:0]  sel_q;
  logic                 bcast_q;
  logic [K_BITS-1:0]    k_q;
  logic                 err_q;
  logic [K_BITS-1:0]    beat_cnt;
  logic [DCNT_BITS-1:0] drain_cnt;
  logic                 ce_q;

  logic             accept;
  logic             bad_cmd;
  logic             beat;
  logic             last_beat;
  logic             drain_last;
  logic             advance;
  logic             inject_live;
  logic             targets_ready;
  logic [RDY_W-1:0] ready_pad;

  // A non-broadcast job aimed past the last array is rejected outright.
  assign bad_cmd = !cmd_broadcast &&
                   ({1'b0, cmd_array} >= (SEL_BITS + 1)'(NUM_ARRAYS));
  assign accept  = (state == S_IDLE) && cmd_valid;

  // Pad ready so any select value indexes safely when NUM_ARRAYS is not 2^n.
  assign ready_pad     = RDY_W'(arr_ready);
  assign targets_ready = bcast_q ? (&arr_ready) : ready_pad[sel_q];

  assign beat        = (state == S_STREAM) && a_valid;
  assign last_beat   = (beat_cnt + K_BITS'(1)) == k_q;
  assign drain_last  = drain_cnt == DCNT_BITS'(DRAIN_CYC - 1);
  assign inject_live = (state == S_STREAM);
  assign advance     = beat || (state == S_DRAIN);

  // State register, latched job fields, beat/drain counters, enable flop.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      bcast_q   <= 1'b0;
      k_q       <= '0;
      err_q     <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      ce_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      ce_q  <= advance;
      if (accept) begin
        sel_q     <= cmd_array;
        bcast_q   <= cmd_broadcast;
        k_q       <= cmd_k;
        err_q     <= bad_cmd;
        beat_cnt  <= '0;
        drain_cnt <= '0;
      end
      if (beat) beat_cnt <= beat_cnt + K_BITS'(1);
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DCNT_BITS'(1);
    end
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (bad_cmd)        state_nxt = S_DONE;
          else if (cmd_clear) state_nxt = S_CLEAR;
          else                state_nxt = S_WAIT_RDY;
        end
      end
      S_CLEAR:    state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (k_q == '0)         state_nxt = S_DONE;
        else if (targets_ready) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (beat && last_beat) state_nxt = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) state_nxt = S_DONE;
      end
      // Hold completion until the final enable pulse has been presented.
      S_DONE: begin
        if (!ce_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-lane skew lines: lane i is a shift line of depth i+1.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_BITS-1:0] sa [0:i];
    logic [DATA_BITS-1:0] sb [0:i];

    // Shift on every advance; stage 0 takes the live lane value or zero in drain.
    // NOTE: the skew stages are plain flops and are reset, since the lane
    // outputs must read zero out of reset and after an abort.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= i; j++) begin
          sa[j] <= '0;
          sb[j] <= '0;
        end
      end else if (advance) begin
        sa[0] <= inject_live ? a_data[i*DATA_BITS +: DATA_BITS] : '0;
        sb[0] <= inject_live ? b_data[i*DATA_BITS +: DATA_BITS] : '0;
        for (int j = 1; j <= i; j++) begin
          sa[j] <= sa[j-1];
          sb[j] <= sb[j-1];
        end
      end
    end

    assign arr_a_flat[i*DATA_BITS +: DATA_BITS] = sa[i];
    assign arr_b_flat[i*DATA_BITS +: DATA_BITS] = sb[i];
  end

  assign cmd_ready          = (state == S_IDLE);
  assign a_ready            = (state == S_STREAM);
  assign busy               = (state != S_IDLE);
  assign arr_select         = sel_q;
  assign arr_broadcast      = bcast_q;
  assign arr_clear_acc      = (state == S_CLEAR);
  assign arr_compute_enable = ce_q;
  assign done_valid         = (state == S_DONE) && !ce_q;
  assign done_err           = done_valid && err_q;
  assign done_array         = (done_valid && !bcast_q) ? sel_q : '0;

endmodule

// File: tb/tb_systolic_cluster_sequencer.sv
// Bench for systolic_cluster_sequencer: directed jobs plus a history-based
// model of the skewed lane outputs checked every cycle.
module tb_systolic_cluster_sequencer;

  localparam int DB = 16;
  localparam int N  = 8;
  localparam int NA = 6;
  localparam int KB = 9;
  localparam int SB = 3;
  localparam int W  = N * DB;
  localparam int DRAIN = 2 * N - 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [SB-1:0] cmd_array = '0;
  logic          cmd_broadcast = 1'b0;
  logic          cmd_clear = 1'b0;
  logic [KB-1:0] cmd_k = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [W-1:0]  a_data = '0;
  logic [W-1:0]  b_data = '0;
  logic [NA-1:0] arr_ready = '1;
  logic [SB-1:0] arr_select;
  logic          arr_broadcast;
  logic          arr_clear_acc;
  logic          arr_compute_enable;
  logic [W-1:0]  arr_a_flat;
  logic [W-1:0]  arr_b_flat;
  logic          done_valid;
  logic [SB-1:0] done_array;
  logic          done_err;
  logic          busy;

  systolic_cluster_sequencer #(
    .DATA_BITS(DB), .ARRAY_SIZE(N), .NUM_ARRAYS(NA), .K_BITS(KB)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_array(cmd_array),
    .cmd_broadcast(cmd_broadcast), .cmd_clear(cmd_clear), .cmd_k(cmd_k),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
    .arr_ready(arr_ready), .arr_select(arr_select), .arr_broadcast(arr_broadcast),
    .arr_clear_acc(arr_clear_acc), .arr_compute_enable(arr_compute_enable),
    .arr_a_flat(arr_a_flat), .arr_b_flat(arr_b_flat),
    .done_valid(done_valid), .done_array(done_array), .done_err(done_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- model state ----------------
  int            cyc = 0;
  bit            job_active = 0;
  logic [SB-1:0] job_array;
  bit            job_bcast, job_clear, job_err;
  int            job_k;
  int            accept_cyc;
  int            pulses = 0;
  int            first_pulse_cyc, last_pulse_cyc;
  int            clear_cnt = 0;
  int            done_count = 0;
  bit            hs_prev = 0, stall_prev = 0;
  logic [W-1:0]  inj_a[$];
  logic [W-1:0]  inj_b[$];

  // Captures for literal checks in the directed sequence.
  int            cap_pulses, cap_span, cap_clear;
  logic [DB-1:0] cap_l7a, cap_l7b;
  logic [SB-1:0] cap_done_array;
  logic          cap_done_err;

  // Lane i at pulse n carries what was injected at advance n-i (beats first,
  // zeros once the beats run out; zeros before the first advance).
  function automatic logic [W-1:0] exp_lanes(input bit use_a, input int n);
    logic [W-1:0] v, src;
    int idx;
    v = '0;
    for (int i = 0; i < N; i++) begin
      idx = n - i;
      if (idx >= 1 && idx <= inj_a.size()) begin
        src = use_a ? inj_a[idx-1] : inj_b[idx-1];
        v[i*DB +: DB] = src[i*DB +: DB];
      end
    end
    return v;
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
      check("rst_ctrl", 128'({busy, a_ready, arr_select, arr_broadcast, arr_clear_acc,
                              arr_compute_enable, done_valid, done_array, done_err}), 128'(0));
      check("rst_arr_a", 128'(arr_a_flat), 128'(0));
      check("rst_arr_b", 128'(arr_b_flat), 128'(0));
      job_active = 0; pulses = 0; hs_prev = 0; stall_prev = 0;
      inj_a.delete(); inj_b.delete();
    end else begin
      check("cmd_ready", 128'(cmd_ready), 128'(!job_active));
      check("busy", 128'(busy), 128'(job_active));
      if (!job_active) check("a_ready_idle", 128'(a_ready), 128'(0));
      if (arr_compute_enable) begin
        pulses++;
        if (pulses == 1) first_pulse_cyc = cyc;
        last_pulse_cyc = cyc;
        if (pulses == 8) begin
          cap_l7a = arr_a_flat[7*DB +: DB];
          cap_l7b = arr_b_flat[7*DB +: DB];
        end
      end
      if (hs_prev)    check("ce_after_beat", 128'(arr_compute_enable), 128'(1));
      if (stall_prev) check("ce_in_stall", 128'(arr_compute_enable), 128'(0));
      if (!job_active || job_err || job_k == 0)
        check("ce_no_job", 128'(arr_compute_enable), 128'(0));
      check("arr_a", 128'(arr_a_flat), 128'(exp_lanes(1'b1, pulses)));
      check("arr_b", 128'(arr_b_flat), 128'(exp_lanes(1'b0, pulses)));
      check("clear_acc", 128'(arr_clear_acc),
            128'(job_active && !job_err && job_clear && cyc == accept_cyc + 1));
      if (arr_clear_acc) clear_cnt++;
      if (job_active && cyc > accept_cyc) begin
        check("arr_select", 128'(arr_select), 128'(job_array));
        check("arr_broadcast", 128'(arr_broadcast), 128'(job_bcast));
      end
      if (done_valid) begin
        check("done_in_job", 128'(job_active), 128'(1));
        check("done_err", 128'(done_err), 128'(job_err));
        check("done_array", 128'(done_array), 128'(job_bcast ? 3'd0 : job_array));
        check("done_pulses", 128'(pulses), 128'((job_err || job_k == 0) ? 0 : job_k + DRAIN));
        check("done_after_ce", 128'(pulses == 0 || last_pulse_cyc < cyc), 128'(1));
        cap_pulses = pulses; cap_clear = clear_cnt;
        cap_span = (pulses == 0) ? 0 : last_pulse_cyc - first_pulse_cyc + 1;
        cap_done_array = done_array; cap_done_err = done_err;
        done_count++;
        job_active = 0;
      end else begin
        check("done_quiet", 128'({done_err, done_array}), 128'(0));
      end
      hs_prev    = a_valid && a_ready;
      stall_prev = a_ready && !a_valid;
      if (hs_prev) begin
        inj_a.push_back(a_data);
        inj_b.push_back(b_data);
      end
      if (cmd_valid && cmd_ready) begin
        job_active = 1; job_array = cmd_array; job_bcast = cmd_broadcast;
        job_clear = cmd_clear; job_k = int'(cmd_k);
        job_err = !cmd_broadcast && (int'(cmd_array) >= NA);
        accept_cyc = cyc; pulses = 0; clear_cnt = 0;
        inj_a.delete(); inj_b.delete();
      end
    end
  end

  // Beat b: A lane i = (i+1) + 0x100*b, B lane i = 0x10*(i+1) + 0x100*b.
  function automatic logic [W-1:0] mk_vec(input int step, input int b);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DB +: DB] = DB'(step * (i + 1) + 16'h100 * b);
    return v;
  endfunction

  task automatic run_job(input logic [SB-1:0] arr, input bit bc, input bit clr, input int k,
                         input int gap, input logic [NA-1:0] rdy, input int rdy_delay,
                         input int abort_at);
    int start_done;
    bit got;
    start_done = done_count;
    arr_ready = rdy;
    cmd_array = arr; cmd_broadcast = bc; cmd_clear = clr; cmd_k = KB'(k); cmd_valid = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); got = cmd_ready;
      @(posedge clk); #1;
    end
    check("cmd_accepted", 128'(got), 128'(1));
    cmd_valid = 1'b0;
    cmd_array = SB'($urandom); cmd_broadcast = 1'($urandom);
    cmd_clear = 1'($urandom); cmd_k = KB'($urandom);
    repeat (rdy_delay) begin
      @(negedge clk);
      check("wait_rdy_ce", 128'(arr_compute_enable), 128'(0));
      check("wait_rdy_a_ready", 128'(a_ready), 128'(0));
      @(posedge clk); #1;
    end
    arr_ready = '1;
    if (bc || int'(arr) < NA) begin
      for (int b = 0; b < k; b++) begin
        a_data = mk_vec(1, b); b_data = mk_vec(16, b); a_valid = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
          @(negedge clk); got = a_ready;
          @(posedge clk); #1;
        end
        check("beat_accepted", 128'(got), 128'(1));
        a_valid = 1'b0;
        a_data = {4{$urandom}}; b_data = {4{$urandom}};
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    if (abort_at > 0) begin
      for (int t = 0; t < 100 && pulses < abort_at; t++) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_ce", 128'(arr_compute_enable), 128'(0));
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_lanes", 128'(arr_a_flat | arr_b_flat), 128'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", 128'(done_count), 128'(start_done));
    end else begin
      for (int t = 0; t < 200 && done_count == start_done; t++) @(negedge clk);
      @(posedge clk); #1;
      check("job_done", 128'(done_count), 128'(start_done + 1));
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    // Reset held with random inputs.
    repeat (5) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom); cmd_array = SB'($urandom); cmd_broadcast = 1'($urandom);
      cmd_clear = 1'($urandom); cmd_k = KB'($urandom); a_valid = 1'($urandom);
      a_data = {4{$urandom}}; b_data = {4{$urandom}}; arr_ready = NA'($urandom);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; a_valid = 1'b0; arr_ready = '1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_reset_ready", 128'(cmd_ready), 128'(1));
    check("post_reset_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;

    // Single job: array 3, clear, k=4, back-to-back beats.
    run_job(3'd3, 1'b0, 1'b1, 4, 0, '1, 0, 0);
    check("single_pulses", 128'(cap_pulses), 128'(18));
    check("single_span", 128'(cap_span), 128'(18));
    check("single_clear", 128'(cap_clear), 128'(1));
    check("single_lane7_a", 128'(cap_l7a), 128'(16'h0008));
    check("single_lane7_b", 128'(cap_l7b), 128'(16'h0080));
    check("single_done_array", 128'(cap_done_array), 128'(3));
    check("single_done_err", 128'(cap_done_err), 128'(0));

    // Stall: k=3 with a_valid 1,0,1,0,1.
    run_job(3'd1, 1'b0, 1'b0, 3, 1, '1, 0, 0);
    check("stall_pulses", 128'(cap_pulses), 128'(17));
    check("stall_clear", 128'(cap_clear), 128'(0));

    // Broadcast waits for every array to be ready.
    run_job(3'd2, 1'b1, 1'b0, 2, 0, 6'b110111, 5, 0);
    check("bcast_pulses", 128'(cap_pulses), 128'(16));
    check("bcast_done_array", 128'(cap_done_array), 128'(0));

    // k=0 with clear: one clear pulse, no compute.
    run_job(3'd0, 1'b0, 1'b1, 0, 0, '1, 0, 0);
    check("k0_clear", 128'(cap_clear), 128'(1));
    check("k0_pulses", 128'(cap_pulses), 128'(0));

    // Out-of-range targets are rejected; last valid index runs.
    run_job(3'd7, 1'b0, 1'b1, 5, 0, '1, 0, 0);
    check("err7_done_err", 128'(cap_done_err), 128'(1));
    check("err7_clear", 128'(cap_clear), 128'(0));
    check("err7_pulses", 128'(cap_pulses), 128'(0));
    run_job(3'd6, 1'b0, 1'b0, 2, 0, '1, 0, 0);
    check("err6_done_err", 128'(cap_done_err), 128'(1));
    run_job(3'd5, 1'b0, 1'b0, 1, 0, '1, 0, 0);
    check("arr5_done_err", 128'(cap_done_err), 128'(0));
    check("arr5_pulses", 128'(cap_pulses), 128'(15));

    // Reset during drain, then a fresh job.
    run_job(3'd4, 1'b0, 1'b1, 2, 0, '1, 0, 2 + 5);
    run_job(3'd1, 1'b0, 1'b0, 2, 0, '1, 0, 0);
    check("fresh_pulses", 128'(cap_pulses), 128'(16));
    check("fresh_done_array", 128'(cap_done_array), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_cluster_sequencer.md
Name: systolic_cluster_sequencer

Overview:
Command-driven front-end for the systolic array cluster. It accepts one matrix-tile job at a time, with a target array or broadcast, a reduction length K and an optional accumulator clear. It streams K beats of A/B row/column vectors into the selected array(s) with diagonal input skew, then drains the pipeline and reports completion. It replaces direct testbench driving of array_select/clear_acc/compute_enable with a handshaked sequencer that generalises over array size and cluster width.

Parameters:
DATA_BITS, 16, element width (Q1.15 fixed point).
ARRAY_SIZE, 8, N: PE rows/cols per array; number of skew lanes.
NUM_ARRAYS, 8, arrays in cluster; need not be a power of two.
K_BITS, 9, width of cmd_k (max K = 2^K_BITS-1).
SEL_BITS, $clog2(NUM_ARRAYS) (minimum 1), width of array select.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  job request.
cmd_ready  out  1  sequencer can accept a job.
cmd_array  in  SEL_BITS  target array index.
cmd_broadcast  in  1  drive all arrays; cmd_array ignored.
cmd_clear  in  1  pulse accumulator clear before streaming.
cmd_k  in  K_BITS  number of input beats.
a_valid  in  1  input beat available.
a_ready  out  1  sequencer consumes beat.
a_data  in  ARRAY_SIZE*DATA_BITS  A vector; lane i at [i*DATA_BITS +: DATA_BITS].
b_data  in  ARRAY_SIZE*DATA_BITS  B vector, same packing; consumed with a_data.
arr_ready  in  NUM_ARRAYS  per-array ready from cluster.
arr_select  out  SEL_BITS  latched target.
arr_broadcast  out  1  latched broadcast flag.
arr_clear_acc  out  1  one-cycle clear pulse.
arr_compute_enable  out  1  skewed data on arr_a/arr_b valid this cycle.
arr_a_flat  out  ARRAY_SIZE*DATA_BITS  skewed A lanes.
arr_b_flat  out  ARRAY_SIZE*DATA_BITS  skewed B lanes.
done_valid  out  1  one-cycle job completion pulse.
done_array  out  SEL_BITS  array of completed job.
done_err  out  1  qualifies done_valid; job rejected.
busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except cmd_ready=1; skew registers cleared; latched cmd fields 0. Reset asserted mid-job aborts it with no done pulse.
- FSM states: IDLE, CLEAR, WAIT_RDY, STREAM, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch array/broadcast/clear/k and drive arr_select/arr_broadcast from the latch.
  - If !cmd_broadcast and cmd_array>=NUM_ARRAYS: go to DONE with done_err=1 and no array activity.
  - Otherwise go to CLEAR if cmd_clear, else WAIT_RDY.
- CLEAR: arr_clear_acc=1 for exactly one cycle, then WAIT_RDY.
- WAIT_RDY: advance to STREAM when arr_ready[sel]=1, or &arr_ready when broadcast. If k==0, go directly to DONE instead.
- STREAM: a_ready=1. Each beat (a_valid&a_ready) is one "advance":
  - per lane i, the skew line of depth i+1 shifts and stage 0 loads the new lane value;
  - the beat counter increments; after the k-th beat go to DRAIN.
  - a_valid=0 is a stall: no shift, arr_compute_enable=0, outputs hold.
- DRAIN: exactly 2*ARRAY_SIZE-2 cycles. Each cycle is an advance with zeros injected at stage 0. Then go to DONE.
- Skew: arr_a/arr_b lane i = lane-i value injected i advances before the current one. Outputs are registered, so lane 0 of a beat accepted in cycle t appears at t+1 and lane i at the (i+1)-th advance.
- arr_compute_enable: registered copy of "advance occurred". Total pulses per job = k + 2*ARRAY_SIZE-2 (0 for k==0 or error).
- DONE: done_valid=1 for one cycle, no earlier than the cycle after the last arr_compute_enable pulse. done_array = latched array (0 when broadcast). Return to IDLE; cmd_ready rises the following cycle, so there are no back-to-back accepts.
- cmd_ready=0 and a_ready=0 outside IDLE and STREAM respectively. Fields change while not ready are ignored.
- arr_ready deasserting during STREAM/DRAIN is ignored; it is sampled only in WAIT_RDY.
- No arithmetic beyond counters. The beat counter is K_BITS wide and compared for equality, so it never wraps.

Test Plan:
- Reset: hold reset=0 with random inputs -> cmd_ready=1, busy=0, all other outputs 0; release -> unchanged until cmd_valid.
- Single job: array=3, clear=1, k=4, a lane i=i+1, b lane i=0x10*(i+1), a_valid constant.
  - arr_clear_acc pulses once, 1 cycle after accept.
  - arr_compute_enable high for 4+14=18 consecutive cycles.
  - lane 7 carries first beat's 0x0008/0x0080 on pulse 8.
  - done_valid with done_array=3, done_err=0.
- Stall: k=3 with a_valid toggling 1,0,1,0,1 -> arr_compute_enable low in gap cycles, outputs held, still exactly 17 pulses, done_valid fires.
- Broadcast wait: broadcast=1, arr_ready=8'b11110111 for 5 cycles then 8'hFF -> no compute_enable until all ready; arr_broadcast=1; done_array=0.
- Edge commands: k=0, clear=1 -> one clear pulse, zero compute pulses, done_valid. With NUM_ARRAYS=6, cmd_array=7 -> done_err=1, no clear/compute pulses.
- Mid-job reset: assert reset during DRAIN cycle 5 -> outputs 0 immediately, no done_valid; a fresh job afterwards completes normally.
